// File: rtl/stopwatch_counter.sv
// Minutes:seconds BCD time-base (00:00-59:59) driven by pre-generated tick enables,
// with run/pause toggling and a per-field adjust mode stepped by the 2 Hz tick.
module stopwatch_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       rollover
);

    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       run_q, run_d;
    logic       running_q, running_d;
    logic       rollover_q, rollover_d;
    logic       sec_at_max;
    logic       min_at_max;

    // Two-digit BCD step over 00..59; 59 wraps to 00 (caller decides on carry).
    function automatic logic [7:0] bcd59_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [3:0] t_next;
        logic [3:0] o_next;
        if (ones == 4'd9) begin
            o_next = 4'd0;
            t_next = (tens == 4'd5) ? 4'd0 : tens + 4'd1;
        end else begin
            o_next = ones + 4'd1;
            t_next = tens;
        end
        return {t_next, o_next};
    endfunction

    assign sec_at_max = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
    assign min_at_max = (min_tens_q == 4'd5) && (min_ones_q == 4'd9);

    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        run_d      = run_q;
        rollover_d = 1'b0;

        if (adj) begin
            // Adjust: only the selected field moves, no carry, run flag frozen.
            if (tick_2hz) begin
                if (sel) begin
                    {sec_tens_d, sec_ones_d} = bcd59_inc(sec_tens_q, sec_ones_q);
                end else begin
                    {min_tens_d, min_ones_d} = bcd59_inc(min_tens_q, min_ones_q);
                end
            end
        end else begin
            run_d = run_q ^ pause;
            // Increment uses the pre-toggle run flag.
            if (run_q && tick_1hz) begin
                {sec_tens_d, sec_ones_d} = bcd59_inc(sec_tens_q, sec_ones_q);
                if (sec_at_max) begin
                    {min_tens_d, min_ones_d} = bcd59_inc(min_tens_q, min_ones_q);
                    rollover_d = min_at_max;
                end
            end
        end

        running_d = !adj && run_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            run_q      <= 1'b0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            run_q      <= run_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign running  = running_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios plus random traffic, all checked
// against a reference model that keeps minutes/seconds as plain integers.
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       pause = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, rollover;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    // Reference state
    int m_min = 0;
    int m_sec = 0;
    bit m_run = 1'b0;
    bit m_running = 1'b0;
    bit m_roll = 1'b0;

    always #5 clk = ~clk;

    stopwatch_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .pause    (pause),
        .adj      (adj),
        .sel      (sel),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .rollover (rollover)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd_time(input int mm, input int ss);
        logic [15:0] v;
        v[15:12] = 4'(mm / 10);
        v[11:8]  = 4'(mm % 10);
        v[7:4]   = 4'(ss / 10);
        v[3:0]   = 4'(ss % 10);
        return v;
    endfunction

    function automatic logic [15:0] dut_time();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Reference model: time as a count of seconds, mode from adj and run flag.
    task automatic model_edge(input bit r, input bit t1, input bit t2, input bit p,
                              input bit a, input bit s);
        int total;
        if (!r) begin
            m_min = 0; m_sec = 0; m_run = 0; m_running = 0; m_roll = 0;
        end else if (a) begin
            m_roll = 0;
            if (t2) begin
                if (s) m_sec = (m_sec + 1) % 60;
                else   m_min = (m_min + 1) % 60;
            end
            m_running = 0;
        end else begin
            m_roll = 0;
            if (m_run && t1) begin
                total = (m_min * 60 + m_sec + 1) % 3600;
                m_roll = (total == 0);
                m_min = total / 60;
                m_sec = total % 60;
            end
            m_run = m_run ^ p;
            m_running = m_run;
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 ns later.
    task automatic cycle(input bit r, input bit t1, input bit t2, input bit p,
                         input bit a, input bit s);
        rst_n = r; tick_1hz = t1; tick_2hz = t2; pause = p; adj = a; sel = s;
        @(posedge clk);
        model_edge(r, t1, t2, p, a, s);
        #1;
        check_eq("digits", 32'(dut_time()), 32'(bcd_time(m_min, m_sec)));
        check_eq("running", 32'(running), 32'(m_running));
        check_eq("rollover", 32'(rollover), 32'(m_roll));
        if (verbose)
            $display("txn rst_n=%0b t1=%0b t2=%0b pause=%0b adj=%0b sel=%0b -> %0h%0h:%0h%0h run=%0b roll=%0b",
                     r, t1, t2, p, a, s, min_tens, min_ones, sec_tens, sec_ones, running, rollover);
    endtask

    // Step the fields in ADJUST until the model shows mm:ss (each loop bounded by 60).
    task automatic adjust_to(input int mm, input int ss);
        for (int i = 0; i < 60 && m_min != mm; i++) cycle(1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 60 && m_sec != ss; i++) cycle(1, 0, 1, 0, 1, 1);
    endtask

    initial begin
        // Reset and run
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_eq("reset_digits", 32'(dut_time()), 32'h0000);
        check_eq("reset_running", 32'(running), 32'h0);
        cycle(1, 0, 0, 1, 0, 0);
        check_eq("pause_runs", 32'(running), 32'h1);
        for (int i = 0; i < 75; i++) cycle(1, 1, 0, 0, 0, 0);
        check_eq("run_75", 32'(dut_time()), 32'h0115);

        // Full rollover
        adjust_to(59, 58);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("exit_adj_running", 32'(running), 32'h1);
        cycle(1, 1, 0, 0, 0, 0);
        check_eq("at_5959", 32'(dut_time()), 32'h5959);
        check_eq("no_roll_5959", 32'(rollover), 32'h0);
        cycle(1, 1, 0, 0, 0, 0);
        check_eq("wrap_0000", 32'(dut_time()), 32'h0000);
        check_eq("wrap_roll", 32'(rollover), 32'h1);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("roll_one_cycle", 32'(rollover), 32'h0);

        // Pause hold
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 0);
        check_eq("pause_hold", 32'(dut_time()), 32'h0010);
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check_eq("resume", 32'(dut_time()), 32'h0011);

        // Adjust wrap, no carry
        adjust_to(3, 58);
        cycle(1, 0, 1, 0, 1, 1);
        check_eq("adj_0359", 32'(dut_time()), 32'h0359);
        cycle(1, 0, 1, 0, 1, 1);
        check_eq("adj_0300", 32'(dut_time()), 32'h0300);
        cycle(1, 1, 1, 0, 1, 1);
        check_eq("adj_0301", 32'(dut_time()), 32'h0301);
        adjust_to(58, 1);
        cycle(1, 0, 1, 0, 1, 0);
        check_eq("adj_5901", 32'(dut_time()), 32'h5901);
        cycle(1, 0, 1, 0, 1, 0);
        check_eq("adj_0001", 32'(dut_time()), 32'h0001);

        // Simultaneous events (run flag is still set)
        adjust_to(0, 5);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 0, 0);
        check_eq("tick_pause_run", 32'(dut_time()), 32'h0006);
        check_eq("tick_pause_run_r", 32'(running), 32'h0);
        cycle(1, 1, 0, 1, 0, 0);
        check_eq("tick_pause_paused", 32'(dut_time()), 32'h0006);
        check_eq("tick_pause_paused_r", 32'(running), 32'h1);
        cycle(1, 0, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("pause_in_adj", 32'(running), 32'h1);
        cycle(1, 1, 0, 0, 1, 0);
        check_eq("adj_rise_drop", 32'(dut_time()), 32'h0006);
        cycle(1, 1, 0, 0, 0, 0);
        check_eq("adj_fall_count", 32'(dut_time()), 32'h0007);

        // Reset mid-adjust
        adjust_to(12, 34);
        cycle(0, 0, 1, 0, 1, 1);
        check_eq("rst_adj_digits", 32'(dut_time()), 32'h0000);
        check_eq("rst_adj_running", 32'(running), 32'h0);
        cycle(1, 0, 1, 0, 1, 1);
        check_eq("post_rst_adj", 32'(dut_time()), 32'h0001);

        // Random traffic
        verbose = 1'b0;
        begin
            bit a_lvl = 1'b0;
            bit s_lvl = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 39) == 0) a_lvl = ~a_lvl;
                if ($urandom_range(0, 19) == 0) s_lvl = ~s_lvl;
                cycle($urandom_range(0, 299) != 0,
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 9) == 0,
                      a_lvl, s_lvl);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
